// File: rtl/cp0_ctrl.sv
// Coprocessor-0 control block: Count/Compare timer, Status/Cause/EPC/EBase
// registers, interrupt pending logic and exception entry/return sequencing.
module cp0_ctrl #(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [11:0] EXC_OFFSET = 12'h180
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic                  eret,
    output logic                  int_pending,
    output logic [31:0]           exc_vector,
    output logic [31:0]           epc_out,
    output logic [31:0]           status,
    output logic [31:0]           cause,
    output logic [31:0]           epc,
    output logic [31:0]           ebase,
    output logic [31:0]           count,
    output logic [31:0]           compare
);

    localparam int            PW       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0]         presc;
    logic                  ti;
    logic                  bd;
    logic [4:0]            exc_code_q;
    logic [1:0]            ip_sw;
    logic [NUM_HW_INT-1:0] hw_q;
    logic [31:0]           status_q;
    logic [31:0]           epc_q;
    logic [31:0]           ebase_q;
    logic [31:0]           count_q;
    logic [31:0]           compare_q;

    logic [31:0] cause_val;
    logic [5:0]  hw_field;
    logic [31:0] count_inc;
    logic        tick;
    logic        take_we;
    logic        count_wr;
    logic        compare_wr;

    always_comb begin
        tick       = (presc == PRE_LAST);
        count_inc  = count_q + 32'd1;
        // exc_req > eret > we: a write only lands when neither event is present
        take_we    = we & ~exc_req & ~eret;
        count_wr   = take_we && (waddr == 5'd9);
        compare_wr = take_we && (waddr == 5'd11);
    end

    // TI is folded into IP7 so software sees the timer as interrupt line 7
    always_comb begin
        hw_field                 = '0;
        hw_field[NUM_HW_INT-1:0] = hw_q;
        cause_val                = '0;
        cause_val[31]            = bd;
        cause_val[30]            = ti;
        cause_val[15:10]         = hw_field | {ti, 5'b0};
        cause_val[9:8]           = ip_sw;
        cause_val[6:2]           = exc_code_q;
    end

    always_comb begin
        int_pending = status_q[0] & ~status_q[1] & (|(cause_val[15:8] & status_q[15:8]));
        exc_vector  = {ebase_q[31:12], EXC_OFFSET};
        epc_out     = epc_q;
        status      = status_q;
        cause       = cause_val;
        epc         = epc_q;
        ebase       = ebase_q;
        count       = count_q;
        compare     = compare_q;
    end

    always_comb begin
        rdata = '0;
        if (!rst) begin
            case (raddr)
                5'd9:    rdata = count_q;
                5'd11:   rdata = compare_q;
                5'd12:   rdata = status_q;
                5'd13:   rdata = cause_val;
                5'd14:   rdata = epc_q;
                5'd15:   rdata = ebase_q;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            ti         <= 1'b0;
            bd         <= 1'b0;
            exc_code_q <= '0;
            ip_sw      <= '0;
            hw_q       <= '0;
            status_q   <= 32'h1000_0000;
            epc_q      <= '0;
            ebase_q    <= '0;
            count_q    <= '0;
            compare_q  <= '0;
        end else begin
            hw_q <= hw_int;

            // A Count write replaces any increment due this cycle
            if (count_wr) begin
                count_q <= wdata;
                presc   <= '0;
            end else if (tick) begin
                presc   <= '0;
                count_q <= count_inc;
                if (count_inc == compare_q)
                    ti <= 1'b1;
            end else begin
                presc <= presc + PW'(1);
            end

            if (compare_wr)
                ti <= 1'b0;

            if (exc_req) begin
                exc_code_q <= exc_code;
                if (!status_q[1]) begin
                    epc_q       <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                    bd          <= exc_bd;
                    status_q[1] <= 1'b1;
                end
            end else if (eret) begin
                status_q[1] <= 1'b0;
            end else if (we) begin
                case (waddr)
                    5'd11:   compare_q <= wdata;
                    5'd12:   status_q  <= wdata;
                    5'd13:   ip_sw     <= wdata[9:8];
                    5'd14:   epc_q     <= wdata;
                    5'd15:   ebase_q   <= wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed scenarios plus randomized traffic, all checked
// against a field-level reference model of the coprocessor registers.
module tb_cp0_ctrl;

    localparam int NHW = 6;
    localparam int DIV = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [4:0]     raddr;
    logic [31:0]    rdata;
    logic           we;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic [NHW-1:0] hw_int;
    logic           exc_req;
    logic [4:0]     exc_code;
    logic [31:0]    exc_pc;
    logic           exc_bd;
    logic           eret;
    logic           int_pending;
    logic [31:0]    exc_vector;
    logic [31:0]    epc_out;
    logic [31:0]    status;
    logic [31:0]    cause;
    logic [31:0]    epc;
    logic [31:0]    ebase;
    logic [31:0]    count;
    logic [31:0]    compare;

    int total = 0;
    int bad   = 0;

    cp0_ctrl #(.NUM_HW_INT(NHW), .COUNT_DIV(DIV), .EXC_OFFSET(12'h180)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata), .hw_int(hw_int),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .eret(eret), .int_pending(int_pending), .exc_vector(exc_vector),
        .epc_out(epc_out), .status(status), .cause(cause), .epc(epc),
        .ebase(ebase), .count(count), .compare(compare)
    );

    always #5 clk = ~clk;

    // Reference model: register fields plus elapsed cycles since the last prescaler clear
    logic [31:0] m_status, m_epc, m_ebase, m_count, m_compare;
    logic        m_ti, m_bd;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    int unsigned m_cyc;

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c        = '0;
        c[31]    = m_bd;
        c[30]    = m_ti;
        c[15:10] = m_hw;
        c[15]    = m_hw[5] | m_ti;
        c[9:8]   = m_ipsw;
        c[6:2]   = m_code;
        return c;
    endfunction

    function automatic logic m_pending();
        logic [31:0] c;
        c = m_cause();
        return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return m_ebase;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit tick, cnt_wr, cmp_wr;
        if (rst) begin
            m_status = 32'h1000_0000;
            m_epc = 0; m_ebase = 0; m_count = 0; m_compare = 0;
            m_ti = 0; m_bd = 0; m_code = 0; m_ipsw = 0; m_hw = 0; m_cyc = 0;
            return;
        end
        tick   = (m_cyc % DIV) == DIV - 1;
        cnt_wr = !exc_req && !eret && we && waddr == 5'd9;
        cmp_wr = !exc_req && !eret && we && waddr == 5'd11;
        m_hw   = hw_int;
        if (cnt_wr) begin
            m_count = wdata;
            m_cyc   = 0;
        end else begin
            m_cyc = m_cyc + 1;
            if (tick) begin
                m_count = m_count + 1;
                if (m_count == m_compare) m_ti = 1;
            end
        end
        if (cmp_wr) m_ti = 0;
        if (exc_req) begin
            if (!m_status[1]) begin
                m_epc       = exc_bd ? exc_pc - 4 : exc_pc;
                m_bd        = exc_bd;
                m_status[1] = 1;
            end
            m_code = exc_code;
        end else if (eret) begin
            m_status[1] = 0;
        end else if (we) begin
            case (waddr)
                5'd11: m_compare = wdata;
                5'd12: m_status  = wdata;
                5'd13: m_ipsw    = wdata[9:8];
                5'd14: m_epc     = wdata;
                5'd15: m_ebase   = wdata;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("status", status, m_status);
        chk("cause", cause, m_cause());
        chk("epc", epc, m_epc);
        chk("ebase", ebase, m_ebase);
        chk("count", count, m_count);
        chk("compare", compare, m_compare);
        chk("int_pending", {31'b0, int_pending}, {31'b0, m_pending()});
        chk("exc_vector", exc_vector, {m_ebase[31:12], 12'h180});
        chk("epc_out", epc_out, m_epc);
        chk("rdata", rdata, rst ? 32'd0 : m_read(raddr));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; we = 0; waddr = 0; wdata = 0; exc_req = 0; exc_code = 0;
        exc_pc = 0; exc_bd = 0; eret = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1; waddr = a; wdata = d;
        step();
        we = 0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bdv);
        exc_req = 1; exc_code = code; exc_pc = pc; exc_bd = bdv;
        step();
        exc_req = 0; exc_bd = 0;
    endtask

    initial begin
        idle();
        hw_int = 0;
        raddr  = 5'd12;
        rst    = 1;
        #1;
        chk("rdata_in_reset", rdata, 32'd0);
        step();
        step();
        chk("reset_status", status, 32'h1000_0000);
        chk("reset_cause", cause, 32'd0);
        chk("reset_pending", {31'b0, int_pending}, 32'd0);
        rst = 0;
        step();

        // Timer: Compare=5, Count=0, TI after ten clocks, cleared by a Compare write
        raddr = 5'd13;
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        repeat (9) step();
        chk("timer_ti_early", {31'b0, cause[30]}, 32'd0);
        step();
        chk("timer_count", count, 32'd5);
        chk("timer_ti", {31'b0, cause[30]}, 32'd1);
        chk("timer_ip7", {31'b0, cause[15]}, 32'd1);
        wr(5'd11, 32'd1000);
        chk("timer_ti_clr", {31'b0, cause[30]}, 32'd0);

        // Hardware interrupt 0 with IE and IM2, then masked by EXL
        wr(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        step();
        chk("irq_cause10", {31'b0, cause[10]}, 32'd1);
        chk("irq_pending", {31'b0, int_pending}, 32'd1);
        wr(5'd12, 32'h0000_0403);
        chk("irq_exl_mask", {31'b0, int_pending}, 32'd0);
        wr(5'd12, 32'h0000_0401);
        hw_int = 0;
        step();

        // Exception in a delay slot, then a nested one, then return
        raddr = 5'd14;
        exc(5'd8, 32'h100, 1'b1);
        chk("bd_epc", epc, 32'hFC);
        chk("bd_flag", {31'b0, cause[31]}, 32'd1);
        chk("bd_code", {27'b0, cause[6:2]}, 32'd8);
        chk("bd_exl", {31'b0, status[1]}, 32'd1);
        exc(5'd0, 32'h200, 1'b0);
        chk("nest_epc", epc, 32'hFC);
        chk("nest_code", {27'b0, cause[6:2]}, 32'd0);
        eret = 1;
        step();
        eret = 0;
        chk("eret_exl", {31'b0, status[1]}, 32'd0);

        // exc_req, eret and an EPC write together: exception wins
        eret = 1; we = 1; waddr = 5'd14; wdata = 32'hDEAD;
        exc(5'd3, 32'h300, 1'b0);
        eret = 0; we = 0;
        chk("prio_epc", epc, 32'h300);
        chk("prio_exl", {31'b0, status[1]}, 32'd1);
        chk("prio_code", {27'b0, cause[6:2]}, 32'd3);

        // Cause write only reaches IP[1:0]
        wr(5'd13, 32'hFFFF_FFFF);
        chk("cause_ipsw", {30'b0, cause[9:8]}, 32'd3);

        // Reset overrides a concurrent exception and write
        rst = 1; exc_req = 1; exc_code = 5'd9; exc_pc = 32'h44;
        we = 1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
        #1;
        chk("rdata_rst_live", rdata, 32'd0);
        step();
        idle();
        chk("rst_over_status", status, 32'h1000_0000);
        chk("rst_over_epc", epc, 32'd0);

        // Count wrap onto Compare=0
        wr(5'd11, 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        repeat (DIV) step();
        chk("wrap_count", count, 32'd0);
        chk("wrap_ti", {31'b0, cause[30]}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            rst      = ($urandom_range(0, 149) == 0);
            exc_req  = ($urandom_range(0, 14) == 0);
            eret     = ($urandom_range(0, 11) == 0);
            we       = ($urandom_range(0, 2) == 0);
            hw_int   = NHW'($urandom);
            exc_code = 5'($urandom);
            exc_pc   = $urandom;
            exc_bd   = 1'($urandom);
            raddr    = 5'($urandom_range(8, 16));
            sel      = $urandom_range(0, 6);
            case (sel)
                0: begin waddr = 5'd9;  wdata = $urandom_range(0, 12); end
                1: begin waddr = 5'd11; wdata = $urandom_range(0, 16); end
                2: begin waddr = 5'd12; wdata = $urandom; end
                3: begin waddr = 5'd13; wdata = $urandom; end
                4: begin waddr = 5'd14; wdata = $urandom; end
                5: begin waddr = 5'd15; wdata = $urandom; end
                default: begin waddr = 5'($urandom); wdata = $urandom; end
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
